// File: rtl/vx_fpu_req_buf.sv
// rtl/vx_fpu_req_buf.sv - round-robin multi-channel FPU request buffer with tagged FWFT FIFO output
// Optional cycle counters are enabled with FPU_REQ_BUF_PERF_EN.
module vx_fpu_req_buf #(
    parameter int NUM_REQS      = 2,
    parameter int DEPTH         = 4,
    parameter int NW_BITS       = 2,
    parameter int NUM_THREADS   = 4,
    parameter int INST_FPU_BITS = 4,
    parameter int INST_MOD_BITS = 3,
    parameter int NR_BITS       = 5,
    localparam int DATAW = NW_BITS + NUM_THREADS + 32 + INST_FPU_BITS + INST_MOD_BITS
                         + 3 * NUM_THREADS * 32 + NR_BITS + 1,
    localparam int TAGW  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQS-1:0]       in_valid,
    input  logic [NUM_REQS*DATAW-1:0] in_data,
    output logic [NUM_REQS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic [TAGW-1:0]           out_tag,
    input  logic                      out_ready
`ifdef FPU_REQ_BUF_PERF_EN
    ,
    output logic [31:0]               perf_stall_cycles,
    output logic [31:0]               perf_full_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [TAGW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TAGW+DATAW-1:0] mem_q [DEPTH];
    logic [TAGW+DATAW-1:0] head;

    logic                  pop;
    logic                  can_push;
    logic                  push;
    logic                  found;
    logic [NUM_REQS-1:0]   grant;
    logic [TAGW-1:0]       grant_idx;
    logic [TAGW-1:0]       arb_sel;
    int                    arb_idx;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign can_push  = (count_q < CW'(DEPTH)) | pop;

    // Scan channels starting at rr_ptr; first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        arb_idx   = 0;
        arb_sel   = '0;
        if (NUM_REQS == 1) begin
            grant[0] = can_push;
        end else if (can_push) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                arb_idx = int'(rr_ptr_q) + i;
                if (arb_idx >= NUM_REQS) begin
                    arb_idx = arb_idx - NUM_REQS;
                end
                arb_sel = TAGW'(arb_idx);
                if (!found && in_valid[arb_sel]) begin
                    found          = 1'b1;
                    grant[arb_sel] = 1'b1;
                    grant_idx      = arb_sel;
                end
            end
        end
    end

    // Reset gates the grant so no channel is accepted while reset_n is low.
    assign in_ready = grant & {NUM_REQS{reset_n}};
    assign push     = |(in_valid & in_ready);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            rr_ptr_d = (grant_idx == TAGW'(NUM_REQS - 1)) ? '0 : grant_idx + TAGW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {grant_idx, in_data[int'(grant_idx) * DATAW +: DATAW]};
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign out_data = head[DATAW-1:0];
    assign out_tag  = (NUM_REQS == 1) ? '0 : (out_valid ? head[TAGW+DATAW-1:DATAW] : '0);

`ifdef FPU_REQ_BUF_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] full_q, full_d;

    always_comb begin
        stall_d = stall_q + ((|in_valid && !push) ? 32'd1 : 32'd0);
        full_d  = full_q + ((count_q == CW'(DEPTH)) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            full_q  <= '0;
        end else begin
            stall_q <= stall_d;
            full_q  <= full_d;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_full_cycles  = full_q;
`endif

endmodule

// File: tb/tb_vx_fpu_req_buf.sv
// tb/tb_vx_fpu_req_buf.sv - scoreboard bench for vx_fpu_req_buf
module tb_vx_fpu_req_buf;

    localparam int NR     = 2;
    localparam int DP     = 4;
    localparam int NWB    = 2;
    localparam int NT     = 4;
    localparam int IFB    = 4;
    localparam int IMB    = 3;
    localparam int NRB    = 5;
    localparam int DW     = NWB + NT + 32 + IFB + IMB + 3 * NT * 32 + NRB + 1;
    localparam int PC_LSB = 1 + NRB + 3 * NT * 32 + IMB + IFB;
    localparam int TW     = 1;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NR-1:0]      in_valid;
    logic [NR*DW-1:0]   in_data;
    logic [NR-1:0]      in_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [TW-1:0]      out_tag;
    logic               out_ready;
`ifdef FPU_REQ_BUF_PERF_EN
    logic [31:0]        perf_stall_cycles;
    logic [31:0]        perf_full_cycles;
`endif

    typedef logic [TW+DW-1:0] ent_t;
    ent_t sb[$];
    int   total = 0;
    int   bad   = 0;

    vx_fpu_req_buf #(
        .NUM_REQS(NR), .DEPTH(DP), .NW_BITS(NWB), .NUM_THREADS(NT),
        .INST_FPU_BITS(IFB), .INST_MOD_BITS(IMB), .NR_BITS(NRB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
        .out_ready(out_ready)
`ifdef FPU_REQ_BUF_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_full_cycles(perf_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] pc);
        logic [DW-1:0] v;
        for (int b = 0; b < DW; b++) v[b] = 1'($urandom_range(0, 1));
        v[PC_LSB +: 32] = pc;
        return v;
    endfunction

    // Monitor: every visible head entry must equal the oldest accepted request.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_head actual=out_valid_1 required=no_entry_pending");
            end else begin
                if ({out_tag, out_data} !== sb[0]) begin
                    bad++;
                    $display("FAIL sb_head actual tag=%0d pc=%h required tag=%0d pc=%h",
                             out_tag, out_data[PC_LSB +: 32], sb[0][DW +: TW], sb[0][PC_LSB +: 32]);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic do_chk, input logic [NR-1:0] exp_rdy, input string name,
                        output int nacc);
        nacc = 0;
        @(negedge clk);
        if (do_chk) chk(name, 32'(in_ready), 32'(exp_rdy));
        for (int i = 0; i < NR; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                sb.push_back({TW'(i), in_data[i*DW +: DW]});
                nacc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = '0;
        reset_n  = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        int na;
        n         = 0;
        in_valid  = '0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 40) begin
            step(1'b0, '0, "", na);
            n++;
        end
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int na;
        int acc;
        int cyc;
`ifdef FPU_REQ_BUF_PERF_EN
        logic [31:0] p0;
`endif
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
`ifdef FPU_REQ_BUF_PERF_EN
        chk("rst_perf_stall", perf_stall_cycles, 32'd0);
        chk("rst_perf_full", perf_full_cycles, 32'd0);
`endif
        reset_n = 1'b1;

        // Single request on ch0 shows up one cycle later
        in_data[0 +: DW] = mk(32'h100);
        in_valid  = 2'b01;
        out_ready = 1'b1;
        step(1'b1, 2'b01, "single_grant", na);
        in_valid = '0;
        @(negedge clk);
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_pc", out_data[PC_LSB +: 32], 32'h100);
        chk("single_tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        #1;
        drain();

        // Fairness: both channels continuously valid
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data  = {mk(32'h200 + 32'(2*k) + 1), mk(32'h200 + 32'(2*k))};
            in_valid = 2'b11;
            step(1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, "fair_grant", na);
        end
        drain();

        // Full: ch1 floods with out_ready low
        do_reset();
        out_ready = 1'b0;
        in_valid  = 2'b10;
        for (int k = 0; k < 6; k++) begin
            in_data[DW +: DW] = mk(32'h300 + 32'(k));
            step(1'b1, (k < 4) ? 2'b10 : 2'b00, "full_grant", na);
        end
`ifdef FPU_REQ_BUF_PERF_EN
        p0 = perf_full_cycles;
        @(posedge clk);
        #1;
        chk("perf_full_inc", perf_full_cycles, p0 + 32'd1);
`endif
        // Full with simultaneous pop: ch0 accepted in the same cycle
        in_valid = 2'b01;
        in_data[0 +: DW] = mk(32'h3A0);
        out_ready = 1'b1;
        step(1'b1, 2'b01, "full_pop_grant", na);
        out_ready = 1'b0;
        step(1'b1, 2'b00, "full_still_full", na);
        drain();

        // Pop on empty is ignored
        out_ready = 1'b1;
        step(1'b0, '0, "", na);
        step(1'b0, '0, "", na);
        in_data[0 +: DW] = mk(32'h400);
        in_valid = 2'b01;
        step(1'b1, 2'b01, "empty_then_push", na);
        drain();

        // Random backpressure
        acc = 0;
        cyc = 0;
        while (acc < 100 && cyc < 2000) begin
            in_valid  = NR'($urandom_range(0, 3));
            in_data   = {mk($urandom), mk($urandom)};
            out_ready = 1'($urandom_range(0, 1));
            step(1'b0, '0, "", na);
            acc += na;
            cyc++;
        end
        chk("rand_accepted_100", 32'(acc >= 100), 32'd1);
        drain();

        // Reset mid-stream with 3 entries queued
        do_reset();
        out_ready = 1'b0;
        in_valid  = 2'b01;
        for (int k = 0; k < 3; k++) begin
            in_data[0 +: DW] = mk(32'h500 + 32'(k));
            step(1'b1, 2'b01, "pre_rst_grant", na);
        end
        in_valid = 2'b11;
        reset_n  = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        in_data = {mk(32'h601), mk(32'h600)};
        step(1'b1, 2'b01, "rst_rr_restart", na);
        in_valid = 2'b10;
        in_data[DW +: DW] = mk(32'h602);
        step(1'b1, 2'b10, "rst_ch1_grant", na);
        in_valid  = '0;
        out_ready = 1'b1;
        step(1'b0, '0, "", na);
        @(negedge clk);
        chk("rst_ch1_tag", 32'(out_tag), 32'd1);
        chk("rst_ch1_pc", out_data[PC_LSB +: 32], 32'h602);
        @(posedge clk);
        #1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
